// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: a fixed-latency multiplier and a radix-2
// restoring divider behind one valid/ready request port, with flush support.
module muldiv_unit #(
    parameter int XLEN          = 32,
    parameter int MUL_STAGES    = 2,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            busy_o
);

    // Handshake: a request is taken at a rising edge where valid_i & ready_o & !flush_i;
    // ready_o is high only in IDLE and valid_o is a one-cycle strobe with no back-pressure.

    localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic            accept;
    logic [1:0]      f3_q, f3_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [4:0]      rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] den_q, den_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;

    // Request-side decode of the divide operands
    logic            in_signed, in_a_neg, in_b_neg, in_div0, in_ovf;
    logic [XLEN-1:0] in_a_mag, in_b_mag, in_spec;

    always_comb begin
        in_signed = ~funct3_i[0];
        in_a_neg  = in_signed & op_a_i[XLEN-1];
        in_b_neg  = in_signed & op_b_i[XLEN-1];
        in_a_mag  = in_a_neg ? -op_a_i : op_a_i;
        in_b_mag  = in_b_neg ? -op_b_i : op_b_i;
        in_div0   = (op_b_i == '0);
        in_ovf    = in_signed & (op_a_i == INT_MIN) & (op_b_i == '1);
        if (funct3_i[1]) begin
            in_spec = in_div0 ? op_a_i : '0;
        end else begin
            in_spec = in_div0 ? '1 : op_a_i;
        end
    end

    assign accept = valid_i & ready_o & ~flush_i;

    // Multiplier: both operands widened to 2*XLEN so one unsigned product covers every variant
    logic            mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0] mul_res;

    assign mul_a_sgn = (f3_q == 2'b01) | (f3_q == 2'b10);
    assign mul_b_sgn = (f3_q == 2'b01);
    assign mul_a     = {{XLEN{mul_a_sgn & op_a_q[XLEN-1]}}, op_a_q};
    assign mul_b     = {{XLEN{mul_b_sgn & op_b_q[XLEN-1]}}, op_b_q};
    assign prod      = mul_a * mul_b;
    assign mul_res   = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Divider step: dividend shifts out of quo_q into the partial remainder
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub, quo_fix, rem_fix, div_res;

    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, den_q});
    assign div_sub   = div_shift[XLEN-1:0] - den_q;
    assign quo_fix   = quo_neg_q ? -quo_q : quo_q;
    assign rem_fix   = rem_neg_q ? -rem_q : rem_q;
    assign div_res   = special_q ? spec_res_q : (f3_q[1] ? rem_fix : quo_fix);

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = funct3_i[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (flush_i || (cnt_q == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_o = (state_q == S_IDLE);
        busy_o  = (state_q != S_IDLE);
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign rd_addr_o = rd_q;

    // Datapath next-state
    always_comb begin
        f3_d       = f3_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        den_d      = den_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d       = funct3_i[1:0];
                    op_a_d     = op_a_i;
                    op_b_d     = op_b_i;
                    rd_d       = rd_addr_i;
                    rem_d      = '0;
                    quo_d      = in_a_mag;
                    den_d      = in_b_mag;
                    quo_neg_d  = in_a_neg ^ in_b_neg;
                    rem_neg_d  = in_a_neg;
                    special_d  = in_div0 | in_ovf;
                    spec_res_d = in_spec;
                    if (!funct3_i[2]) begin
                        cnt_d = CNT_W'(MUL_STAGES - 1);
                    end else if ((in_div0 | in_ovf) && (DIV_EARLY_OUT != 0)) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = CNT_W'(XLEN);
                    end
                end
            end
            S_MUL: begin
                if (!flush_i) begin
                    if (cnt_q == '0) begin
                        result_d = mul_res;
                        valid_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_DIV: begin
                if (!flush_i) begin
                    if (cnt_q == '0) begin
                        result_d = div_res;
                        valid_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        quo_d = {quo_q[XLEN-2:0], div_ge};
                        rem_d = div_ge ? div_sub : div_shift[XLEN-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f3_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            den_q      <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            f3_q       <= f3_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            den_q      <= den_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: one instance with divide early-out and
// one without, sharing the same request stream.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;

    logic            ready_o0, valid_o0, busy_o0;
    logic [XLEN-1:0] result_o0;
    logic [4:0]      rd_addr_o0;
    logic            ready_o1, valid_o1, busy_o1;
    logic [XLEN-1:0] result_o1;
    logic [4:0]      rd_addr_o1;

    int checks = 0;
    int errors = 0;
    int vcnt0  = 0;
    int vcnt1  = 0;

    logic [XLEN+4:0] exp_q0[$];
    logic [XLEN+4:0] exp_q1[$];
    logic [XLEN+4:0] e0, e1;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic [XLEN-1:0] res;
        int              lat_eo;
        int              lat_full;
    } vec_t;

    vec_t vq[$];

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(2), .DIV_EARLY_OUT(1)) u_eo (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o0),
        .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .valid_o(valid_o0), .result_o(result_o0),
        .rd_addr_o(rd_addr_o0), .busy_o(busy_o0)
    );

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(2), .DIV_EARLY_OUT(0)) u_full (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o1),
        .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .valid_o(valid_o1), .result_o(result_o1),
        .rd_addr_o(rd_addr_o1), .busy_o(busy_o1)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected run to complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected {rd, result}
    always @(negedge clk) begin
        if (!rst_i && valid_o0) begin
            vcnt0++;
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_valid_eo: got result %h expected no strobe", result_o0);
            end else begin
                e0 = exp_q0.pop_front();
                check("result_eo", 64'({rd_addr_o0, result_o0}), 64'(e0));
            end
        end
        if (!rst_i && valid_o1) begin
            vcnt1++;
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_valid_full: got result %h expected no strobe", result_o1);
            end else begin
                e1 = exp_q1.pop_front();
                check("result_full", 64'({rd_addr_o1, result_o1}), 64'(e1));
            end
        end
    end

    // Drivers
    task automatic add_vec(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] rd, input logic [XLEN-1:0] res,
                           input int lat_eo, input int lat_full);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.res = res;
        v.lat_eo = lat_eo; v.lat_full = lat_full;
        vq.push_back(v);
    endtask

    task automatic expect_result(input logic [4:0] rd, input logic [XLEN-1:0] res);
        exp_q0.push_back({rd, res});
        exp_q1.push_back({rd, res});
    endtask

    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        funct3_i  = f3;
        op_a_i    = a;
        op_b_i    = b;
        rd_addr_i = rd;
        valid_i   = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("accept_busy", 64'({busy_o0, busy_o1, ready_o0, ready_o1}), 64'(4'b1100));
    endtask

    task automatic wait_done(output int lat0, output int lat1, output bit hold_ok);
        lat0    = -1;
        lat1    = -1;
        hold_ok = 1'b1;
        for (int n = 1; n <= 60 && (lat0 < 0 || lat1 < 0); n++) begin
            @(posedge clk);
            #1;
            if (lat0 < 0) begin
                if (valid_o0) lat0 = n;
                else if (!busy_o0 || ready_o0) hold_ok = 1'b0;
            end
            if (lat1 < 0) begin
                if (valid_o1) lat1 = n;
                else if (!busy_o1 || ready_o1) hold_ok = 1'b0;
            end
        end
    endtask

    initial begin
        int  l0, l1;
        int  snap0, snap1;
        bit  hok;
        logic strobe_seen;

        rst_i     = 1'b1;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        funct3_i  = '0;
        op_a_i    = '0;
        op_b_i    = '0;
        rd_addr_i = '0;

        // MUL family, MUL_STAGES = 2
        add_vec(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2, 2);
        add_vec(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 2, 2);
        add_vec(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 2, 2);
        add_vec(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 2, 2);
        add_vec(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5'd5,  32'hFFFF_FFFF, 2, 2);
        add_vec(3'b011, 32'h8000_0000, 32'h0000_0002, 5'd6,  32'h0000_0001, 2, 2);
        // Regular divides: XLEN iterations plus fixup
        add_vec(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33, 33);
        add_vec(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33, 33);
        add_vec(3'b101, 32'd100,       32'd7,         5'd9,  32'd14,        33, 33);
        add_vec(3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         33, 33);
        add_vec(3'b100, 32'd20,        32'hFFFF_FFFA, 5'd11, 32'hFFFF_FFFD, 33, 33);
        add_vec(3'b110, 32'd20,        32'hFFFF_FFFA, 5'd12, 32'd2,         33, 33);
        add_vec(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 33, 33);
        add_vec(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 33, 33);
        // Divide by zero and signed overflow
        add_vec(3'b101, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1, 33);
        add_vec(3'b110, 32'd5,         32'd0,         5'd16, 32'd5,         1, 33);
        add_vec(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1, 33);
        add_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1, 33);

        repeat (3) @(posedge clk);
        #1;
        check("reset_eo",   64'({valid_o0, result_o0, rd_addr_o0, busy_o0, ready_o0}), 64'({1'b0, 32'd0, 5'd0, 1'b0, 1'b1}));
        check("reset_full", 64'({valid_o1, result_o1, rd_addr_o1, busy_o1, ready_o1}), 64'({1'b0, 32'd0, 5'd0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_i = 1'b0;

        foreach (vq[i]) begin
            expect_result(vq[i].rd, vq[i].res);
            issue(vq[i].f3, vq[i].a, vq[i].b, vq[i].rd);
            wait_done(l0, l1, hok);
            check($sformatf("latency_eo_%0d", i),   64'(l0), 64'(vq[i].lat_eo));
            check($sformatf("latency_full_%0d", i), 64'(l1), 64'(vq[i].lat_full));
            check($sformatf("busy_hold_%0d", i),    64'(hok), 64'(1));
        end

        // Back-to-back: valid_i held high, MUL followed by DIVU
        @(negedge clk);
        expect_result(5'd20, 32'd42);
        expect_result(5'd21, 32'd100);
        funct3_i = 3'b000; op_a_i = 32'd6; op_b_i = 32'd7; rd_addr_i = 5'd20;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        funct3_i = 3'b101; op_a_i = 32'd1000; op_b_i = 32'd10; rd_addr_i = 5'd21;
        check("b2b_mul_accept", 64'({busy_o0, ready_o0}), 64'(2'b10));
        @(posedge clk);
        #1;
        check("b2b_mul_busy", 64'({busy_o0, ready_o0, valid_o0}), 64'(3'b100));
        @(posedge clk);
        #1;
        check("b2b_mul_done", 64'({valid_o0, ready_o0, valid_o1, ready_o1}), 64'(4'b1111));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("b2b_div_accept", 64'({busy_o0, ready_o0, busy_o1, ready_o1}), 64'(4'b1010));
        wait_done(l0, l1, hok);
        check("b2b_div_latency", 64'({l0, l1}), 64'({32'd33, 32'd33}));
        check("b2b_div_hold", 64'(hok), 64'(1));

        // Flush at divide iteration 10, then a MUL right after
        snap0 = vcnt0;
        snap1 = vcnt1;
        issue(3'b100, 32'd1000, 32'd7, 5'd22);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_idle", 64'({valid_o0, busy_o0, ready_o0, valid_o1, busy_o1, ready_o1}), 64'(6'b001001));
        expect_result(5'd23, 32'hFFFF_FFEB);
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd23);
        wait_done(l0, l1, hok);
        check("flush_mul_latency", 64'({l0, l1}), 64'({32'd2, 32'd2}));
        check("flush_strobes", 64'({vcnt0 - snap0, vcnt1 - snap1}), 64'({32'd1, 32'd1}));

        // Flush in the strobe cycle leaves the strobe intact
        expect_result(5'd24, 32'd12);
        issue(3'b000, 32'd3, 32'd4, 5'd24);
        @(posedge clk);
        @(posedge clk);
        #1;
        strobe_seen = valid_o0;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_on_strobe", 64'({strobe_seen, valid_o0, valid_o1}), 64'(3'b111));
        @(posedge clk);
        #1;
        flush_i = 1'b0;

        // Reset mid-divide: outputs cleared, op discarded
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd25);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_eo",   64'({valid_o0, result_o0, rd_addr_o0, busy_o0, ready_o0}), 64'({1'b0, 32'd0, 5'd0, 1'b0, 1'b1}));
        check("midreset_full", 64'({valid_o1, result_o1, rd_addr_o1, busy_o1, ready_o1}), 64'({1'b0, 32'd0, 5'd0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_i = 1'b0;
        snap0 = vcnt0;
        snap1 = vcnt1;
        repeat (40) @(posedge clk);
        #1;
        check("midreset_no_strobe", 64'({vcnt0 - snap0, vcnt1 - snap1}), 64'(0));

        // Flush with valid in IDLE: request must be ignored
        @(negedge clk);
        funct3_i = 3'b000; op_a_i = 32'd9; op_b_i = 32'd9; rd_addr_i = 5'd26;
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("idle_flush_reject", 64'({busy_o0, ready_o0, busy_o1, ready_o1}), 64'(4'b0101));
        repeat (5) @(posedge clk);
        #1;
        check("idle_flush_no_strobe", 64'({vcnt0 - snap0, vcnt1 - snap1}), 64'(0));

        check("drain_eo",   64'(exp_q0.size()), 64'(0));
        check("drain_full", 64'(exp_q1.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle execute unit for the RV32M extension; successor to the single-cycle ALU select decode.
- Sits in EX beside the ALU. The decoder routes OPCODE_R instructions with funct7 = 0000001 here.
- Decodes funct3 internally. Runs a staged multiplier and an iterative radix-2 restoring divider under a valid/ready handshake, with flush and early-out support.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8
- MUL_STAGES, 2, multiply latency in cycles from acceptance to valid_o; must be >= 1
- DIV_EARLY_OUT, 1, 1 = divide-by-zero and signed overflow complete in 1 cycle; 0 = full divide latency

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  operation request
- ready_o  out  1  unit can accept; high only in IDLE
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a_i  in  XLEN  rs1 value
- op_b_i  in  XLEN  rs2 value
- rd_addr_i  in  5  destination register tag
- flush_i  in  1  abort in-flight operation
- valid_o  out  1  one-cycle result strobe
- result_o  out  XLEN  result, meaningful only while valid_o = 1
- rd_addr_o  out  5  tag captured at acceptance
- busy_o  out  1  high in MUL or DIV state (stall request to pipeline)

Behaviour:
- Reset (rst_i = 1 at an edge) produces:
  - state = IDLE, valid_o = 0, result_o = 0, rd_addr_o = 0, busy_o = 0, ready_o = 1
  - all counters and operand registers cleared
  - reset mid-operation discards the op; no valid_o is ever produced for it.
- Acceptance: valid_i & ready_o & !flush_i at an edge. That edge captures operands, funct3 and rd_addr. Inputs are ignored at all other times.
- States: IDLE, MUL, DIV. All outputs are registered.
- funct3[2] = 0 goes to MUL:
  - full 2*XLEN product formed from operands sign/zero-extended per funct3: MULH signed x signed, MULHSU signed x unsigned, MULHU and MUL unsigned (low half identical).
  - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
  - Down-counter loaded with MUL_STAGES-1. valid_o goes high in the cycle MUL_STAGES edges after the acceptance edge.
- funct3[2] = 1 goes to DIV:
  - Signed ops (DIV, REM) divide magnitudes; the quotient is negated if operand signs differ, and the remainder takes the dividend's sign.
  - One quotient bit per cycle, XLEN iterations, then one sign-fixup cycle. valid_o goes high XLEN+1 edges after acceptance.
- Special cases (RISC-V spec):
  - op_b = 0: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed op_a = 100...0 with op_b = all-ones (DIV/REM only): DIV returns op_a, REM returns 0.
  - With DIV_EARLY_OUT = 1, both cases give valid_o 1 edge after acceptance. With DIV_EARLY_OUT = 0, the same values appear at full latency.
- Completion: the edge that sets valid_o also returns state to IDLE. ready_o = 1 in that same cycle, so back-to-back acceptance is allowed. valid_o stays high exactly one cycle; there is no back-pressure.
- Flush:
  - flush_i at an edge in MUL/DIV → IDLE, no valid_o for that op.
  - flush_i with valid_i in IDLE → request not accepted.
  - flush_i in the cycle valid_o = 1 does not retract the strobe already shown.
- busy_o = (state != IDLE), registered consistently with state.
- Arithmetic is wrap-around modulo 2^XLEN; no exceptions or flags.

Test Plan:
- MUL 7 x 0xFFFFFFFD → result 0xFFFFFFEB, valid_o exactly 2 cycles after accept (MUL_STAGES = 2); MULHU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD, valid_o 33 cycles after accept; REM same → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, 1 cycle latency; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0; repeat with DIV_EARLY_OUT = 0 → same values at 33 cycles.
- Back-to-back: hold valid_i high with a MUL then a DIV → second op accepted in the cycle first valid_o = 1; ready_o = 0 and busy_o = 1 throughout each op; rd_addr_o matches each op's tag.
- Flush at iteration 10 of a DIV → no valid_o, ready_o = 1 next cycle; new MUL accepted right after returns the correct value.
- Assert rst_i mid-DIV for 1 cycle → all outputs 0, ready_o = 1, no stale valid_o for 40 cycles; flush_i with valid_i in IDLE → no acceptance, no valid_o.
